// File: rtl/uart_echo_checker.sv
// ---------------------------------------------------------------------------
// uart_echo_checker
//
// Echo test engine for the serial path. On Start it streams NumBytes pattern
// bytes (incrementing from Seed, or an 8-bit LFSR seeded with Seed) into the
// UART transmit handshake. It then checks every byte coming back on the UART
// receive handshake against the expected byte, in order. Up to Window bytes
// may be outstanding at once. Expected bytes wait in a small FIFO until their
// echo arrives.
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset_n       in   synchronous active-low reset
//   Start         in   one-cycle pulse, starts a run (ignored while Busy)
//   Busy          out  run in progress
//   Done          out  run finished, held until next accepted Start/reset
//   Pass          out  valid with Done: all echoed, no errors, no timeout
//   Timeout       out  run aborted by the idle timeout
//   ErrCount      out  mismatches + unexpected bytes, saturating
//   FirstErrIdx   out  index of the first mismatching received byte
//   FirstErrGot   out  value received at FirstErrIdx
//   DataIn        out  byte to UART transmitter
//   DataInValid   out  DataIn valid
//   DataInReady   in   UART transmitter can accept
//   DataOut       in   byte from UART receiver
//   DataOutValid  in   DataOut valid
//   DataOutReady  out  checker accepts the received byte
// ---------------------------------------------------------------------------
module uart_echo_checker #(
   parameter int unsigned NumBytes      = 32'd16,
   parameter logic [7:0]  Seed          = 8'h7a,
   parameter int unsigned PatternMode   = 32'd0,
   parameter int unsigned Window        = 32'd4,
   parameter int unsigned TimeoutCycles = 32'd100_000
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Start,
   output logic        Busy,
   output logic        Done,
   output logic        Pass,
   output logic        Timeout,
   output logic [15:0] ErrCount,
   output logic [15:0] FirstErrIdx,
   output logic [7:0]  FirstErrGot,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);

   localparam int PtrW = (Window > 32'd1) ? $clog2(Window) : 1;
   localparam int OccW = $clog2(Window + 32'd1);

   localparam logic [15:0]     NumBytesC   = 16'(NumBytes);
   localparam logic [OccW-1:0] WindowC     = OccW'(Window);
   localparam logic [PtrW-1:0] LastPtr     = PtrW'(Window - 32'd1);
   localparam logic [31:0]     TimeoutLast = 32'(TimeoutCycles - 32'd1);
   // An all-zero LFSR would lock up, so a zero seed is bumped to 1 in LFSR mode.
   localparam logic [7:0]      SeedEff     =
      ((PatternMode == 32'd1) && (Seed == 8'h00)) ? 8'h01 : Seed;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   function automatic logic [7:0] nextPattern(input logic [7:0] cur);
      if (PatternMode == 32'd1) begin
         nextPattern = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
      end else begin
         nextPattern = cur + 8'd1;
      end
   endfunction

   // Pointers wrap at Window, which need not be a power of two.
   function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
      if (p == LastPtr) begin
         ptrInc = {PtrW{1'b0}};
      end else begin
         ptrInc = p + PtrW'(1'b1);
      end
   endfunction

   function automatic logic [15:0] satInc(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         satInc = v;
      end else begin
         satInc = v + 16'd1;
      end
   endfunction

   state_t          state_r,         stateNext;
   logic            busy_r,          busyNext;
   logic            done_r,          doneNext;
   logic            pass_r,          passNext;
   logic            timeout_r,       timeoutNext;
   logic [15:0]     errCount_r,      errCountNext;
   logic [15:0]     firstErrIdx_r,   firstErrIdxNext;
   logic [7:0]      firstErrGot_r,   firstErrGotNext;
   logic            firstErrSeen_r,  firstErrSeenNext;
   logic [7:0]      dataIn_r,        dataInNext;
   logic            dataInValid_r,   dataInValidNext;
   logic            dataOutReady_r;
   logic [15:0]     sent_r,          sentNext;
   logic [15:0]     received_r,      receivedNext;
   logic [OccW-1:0] occ_r,           occNext;
   logic [PtrW-1:0] wrPtr_r,         wrPtrNext;
   logic [PtrW-1:0] rdPtr_r,         rdPtrNext;
   logic [31:0]     toCnt_r,         toCntNext;
   logic [7:0]      fifoMem_r [Window];

   logic            push_s;
   logic            pop_s;
   logic            unexp_s;
   logic            mismatch_s;
   logic [7:0]      expected_s;

   assign push_s     = (state_r == StRun) && dataInValid_r && DataInReady;
   assign pop_s      = (state_r == StRun) && DataOutValid && dataOutReady_r
                       && (occ_r != {OccW{1'b0}});
   assign unexp_s    = (state_r == StRun) && DataOutValid && dataOutReady_r
                       && (occ_r == {OccW{1'b0}});
   assign expected_s = fifoMem_r[rdPtr_r];
   assign mismatch_s = pop_s && (DataOut != expected_s);

   // Next-state computation for the run FSM, counters, FIFO control and outputs.
   always_comb begin
      stateNext        = state_r;
      timeoutNext      = timeout_r;
      errCountNext     = errCount_r;
      firstErrIdxNext  = firstErrIdx_r;
      firstErrGotNext  = firstErrGot_r;
      firstErrSeenNext = firstErrSeen_r;
      dataInNext       = dataIn_r;
      sentNext         = sent_r;
      receivedNext     = received_r;
      occNext          = occ_r;
      wrPtrNext        = wrPtr_r;
      rdPtrNext        = rdPtr_r;
      toCntNext        = toCnt_r;

      case (state_r)
         StIdle, StDone: begin
            // Received bytes are discarded here; only Start matters.
            if (Start) begin
               stateNext        = StRun;
               timeoutNext      = 1'b0;
               errCountNext     = 16'd0;
               firstErrIdxNext  = 16'd0;
               firstErrGotNext  = 8'd0;
               firstErrSeenNext = 1'b0;
               dataInNext       = SeedEff;
               sentNext         = 16'd0;
               receivedNext     = 16'd0;
               occNext          = {OccW{1'b0}};
               wrPtrNext        = {PtrW{1'b0}};
               rdPtrNext        = {PtrW{1'b0}};
               toCntNext        = 32'd0;
            end else begin
               stateNext        = state_r;
            end
         end

         StRun: begin
            if (push_s) begin
               wrPtrNext  = ptrInc(wrPtr_r);
               sentNext   = sent_r + 16'd1;
               dataInNext = nextPattern(dataIn_r);
            end else begin
               wrPtrNext  = wrPtr_r;
            end

            if (pop_s) begin
               rdPtrNext    = ptrInc(rdPtr_r);
               receivedNext = received_r + 16'd1;
            end else begin
               rdPtrNext    = rdPtr_r;
            end

            // Unexpected bytes count as errors but do not claim FirstErr*.
            if (mismatch_s || unexp_s) begin
               errCountNext = satInc(errCount_r);
            end else begin
               errCountNext = errCount_r;
            end

            if (mismatch_s && !firstErrSeen_r) begin
               firstErrSeenNext = 1'b1;
               firstErrIdxNext  = received_r;
               firstErrGotNext  = DataOut;
            end else begin
               firstErrSeenNext = firstErrSeen_r;
            end

            case ({push_s, pop_s})
               2'b10:   occNext = occ_r + OccW'(1'b1);
               2'b01:   occNext = occ_r - OccW'(1'b1);
               default: occNext = occ_r;
            endcase

            // Idle timer runs only while something is outstanding.
            if (pop_s || (occ_r == {OccW{1'b0}})) begin
               toCntNext = 32'd0;
            end else if (toCnt_r >= TimeoutLast) begin
               toCntNext   = toCnt_r;
               timeoutNext = 1'b1;
               stateNext   = StDone;
            end else begin
               toCntNext = toCnt_r + 32'd1;
            end

            if (receivedNext == NumBytesC) begin
               stateNext = StDone;
            end else begin
               toCntNext = toCntNext;
            end
         end

         default: begin
            stateNext = StIdle;
         end
      endcase

      busyNext        = (stateNext == StRun);
      doneNext        = (stateNext == StDone);
      passNext        = (stateNext == StDone) && (errCountNext == 16'd0) && !timeoutNext;
      dataInValidNext = (stateNext == StRun) && (sentNext < NumBytesC) && (occNext < WindowC);
   end

   // State and registered outputs, with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_r        <= StIdle;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
         timeout_r      <= 1'b0;
         errCount_r     <= 16'd0;
         firstErrIdx_r  <= 16'd0;
         firstErrGot_r  <= 8'd0;
         firstErrSeen_r <= 1'b0;
         dataIn_r       <= 8'd0;
         dataInValid_r  <= 1'b0;
         dataOutReady_r <= 1'b0;
         sent_r         <= 16'd0;
         received_r     <= 16'd0;
         occ_r          <= {OccW{1'b0}};
         wrPtr_r        <= {PtrW{1'b0}};
         rdPtr_r        <= {PtrW{1'b0}};
         toCnt_r        <= 32'd0;
      end else begin
         state_r        <= stateNext;
         busy_r         <= busyNext;
         done_r         <= doneNext;
         pass_r         <= passNext;
         timeout_r      <= timeoutNext;
         errCount_r     <= errCountNext;
         firstErrIdx_r  <= firstErrIdxNext;
         firstErrGot_r  <= firstErrGotNext;
         firstErrSeen_r <= firstErrSeenNext;
         dataIn_r       <= dataInNext;
         dataInValid_r  <= dataInValidNext;
         dataOutReady_r <= 1'b1;
         sent_r         <= sentNext;
         received_r     <= receivedNext;
         occ_r          <= occNext;
         wrPtr_r        <= wrPtrNext;
         rdPtr_r        <= rdPtrNext;
         toCnt_r        <= toCntNext;
      end
   end

   // Expected-byte storage; emptiness is tracked by occ_r, so no reset needed.
   always_ff @(posedge Clock) begin
      if (push_s && Reset_n) begin
         fifoMem_r[wrPtr_r] <= dataIn_r;
      end
   end

   assign Busy         = busy_r;
   assign Done         = done_r;
   assign Pass         = pass_r;
   assign Timeout      = timeout_r;
   assign ErrCount     = errCount_r;
   assign FirstErrIdx  = firstErrIdx_r;
   assign FirstErrGot  = firstErrGot_r;
   assign DataIn       = dataIn_r;
   assign DataInValid  = dataInValid_r;
   assign DataOutReady = dataOutReady_r;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Self-checking bench for uart_echo_checker. Two instances are used:
// A (incrementing, Seed 7a, 4 bytes, Window 2) and B (LFSR, Seed 01, 5 bytes,
// Window 4), both with a 200-cycle timeout. The bench plays the UART loopback
// with random echo delays and random transmitter back-pressure.
module tb_uart_echo_checker;

   localparam int Budget = 2000;
   localparam int ToCycles = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstN;
   logic       start;
   logic       dataInReady;
   logic       dataOutValid;
   logic [7:0] dataOut;
   int         sel;

   logic startA, startB;
   assign startA = start & (sel == 0);
   assign startB = start & (sel == 1);

   logic busyA, doneA, passA, toA, dinVA, doutRA;
   logic [15:0] errA, fIdxA;
   logic [7:0]  fGotA, dinA;
   logic busyB, doneB, passB, toB, dinVB, doutRB;
   logic [15:0] errB, fIdxB;
   logic [7:0]  fGotB, dinB;

   uart_echo_checker #(.NumBytes(4), .Seed(8'h7a), .PatternMode(0), .Window(2),
                       .TimeoutCycles(ToCycles)) dutA (
      .Clock(clk), .Reset_n(rstN), .Start(startA), .Busy(busyA), .Done(doneA),
      .Pass(passA), .Timeout(toA), .ErrCount(errA), .FirstErrIdx(fIdxA),
      .FirstErrGot(fGotA), .DataIn(dinA), .DataInValid(dinVA),
      .DataInReady(dataInReady), .DataOut(dataOut), .DataOutValid(dataOutValid),
      .DataOutReady(doutRA));

   uart_echo_checker #(.NumBytes(5), .Seed(8'h01), .PatternMode(1), .Window(4),
                       .TimeoutCycles(ToCycles)) dutB (
      .Clock(clk), .Reset_n(rstN), .Start(startB), .Busy(busyB), .Done(doneB),
      .Pass(passB), .Timeout(toB), .ErrCount(errB), .FirstErrIdx(fIdxB),
      .FirstErrGot(fGotB), .DataIn(dinB), .DataInValid(dinVB),
      .DataInReady(dataInReady), .DataOut(dataOut), .DataOutValid(dataOutValid),
      .DataOutReady(doutRB));

   // Selected-instance view
   logic busyS, doneS, passS, toS, dinVS, doutRS;
   logic [15:0] errS, fIdxS;
   logic [7:0]  fGotS, dinS;
   assign busyS = sel ? busyB : busyA;
   assign doneS = sel ? doneB : doneA;
   assign passS = sel ? passB : passA;
   assign toS   = sel ? toB   : toA;
   assign dinVS = sel ? dinVB : dinVA;
   assign doutRS = sel ? doutRB : doutRA;
   assign errS  = sel ? errB  : errA;
   assign fIdxS = sel ? fIdxB : fIdxA;
   assign fGotS = sel ? fGotB : fGotA;
   assign dinS  = sel ? dinB  : dinA;

   int vectors = 0;
   int miscompares = 0;

   // Observations recorded by drive_run
   logic [7:0] txLog[$];
   int  cyc, doneCycle, lastClear, lastEchoEdge, maxOut, stabViol, stabChecks;
   bit  runDone;
   logic firstBusy, firstValid;
   logic [7:0] firstData;

   // Reference pattern byte k for instance s
   function automatic logic [7:0] model_byte(input int s, input int k);
      int v;
      if (s == 0) return 8'((32'h7a + k) % 256);
      v = 1;
      for (int i = 0; i < k; i++)
         v = ((v * 2) % 256) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
      return 8'(v);
   endfunction

   function automatic int num_bytes(input int s);
      return (s == 0) ? 4 : 5;
   endfunction

   function automatic int window_of(input int s);
      return (s == 0) ? 2 : 4;
   endfunction

   // Loopback driver: starts a run and plays transmitter + receiver, recording observations.
   task automatic drive_run(input int s, input int corruptIdx, input logic [7:0] corruptVal,
                            input int dropIdx, input int readyHold, input int echoHold,
                            input bit strayAtStart, input int abortAt);
      logic [7:0] echoVal[$];
      int echoRel[$];
      int txCnt, rxCnt, rxIssued, occ, rel;
      bit rdy, prevHeld, clr;
      logic [7:0] prevData, v;
      sel = s;
      txLog.delete();
      txCnt = 0; rxCnt = 0; rxIssued = 0; prevHeld = 0; prevData = 8'd0;
      runDone = 0; doneCycle = -1; lastClear = 0; lastEchoEdge = -1;
      maxOut = 0; stabViol = 0; stabChecks = 0;
      cyc = 0;
      start = 1'b1;
      while (!runDone && cyc < Budget && !(abortAt > 0 && cyc >= abortAt)) begin
         @(posedge clk); #1;
         cyc++;
         start = 1'b0;
         if (cyc == 1) begin
            firstBusy = busyS; firstValid = dinVS; firstData = dinS;
         end
         if (doneS) begin
            runDone = 1; doneCycle = cyc;
         end else begin
            occ = txCnt - rxCnt;
            if (occ > maxOut) maxOut = occ;
            if (prevHeld) begin
               stabChecks++;
               if (!dinVS || dinS !== prevData) stabViol++;
            end
            rdy = (cyc < readyHold) ? 1'b0 : ($urandom_range(0, 3) != 0);
            dataInReady = rdy;
            prevHeld = dinVS & ~rdy;
            prevData = dinS;
            if (dinVS && rdy) begin
               txLog.push_back(dinS);
               echoVal.push_back(dinS);
               rel = cyc + 1 + $urandom_range(0, 3);
               echoRel.push_back((rel < echoHold) ? echoHold : rel);
               txCnt++;
            end
            clr = (occ == 0);
            dataOutValid = 1'b0;
            if (strayAtStart && cyc == 1) begin
               dataOutValid = 1'b1;
               dataOut = 8'($urandom);
            end else if (echoVal.size() > 0 && echoRel[0] <= cyc) begin
               v = echoVal.pop_front();
               rel = echoRel.pop_front();
               if (rxIssued != dropIdx) begin
                  dataOutValid = 1'b1;
                  dataOut = (rxIssued == corruptIdx) ? corruptVal : v;
                  rxCnt++;
                  clr = 1;
                  lastEchoEdge = cyc + 1;
               end
               rxIssued++;
            end
            if (clr) lastClear = cyc + 1;
         end
      end
      start = 1'b0;
      dataOutValid = 1'b0;
      dataInReady = 1'b0;
   endtask

   task automatic test_reset();
      rstN = 1'b0; start = 1'b0; dataInReady = 1'b0; dataOutValid = 1'b0; dataOut = 8'd0; sel = 0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({busyA, doneA, passA, toA, errA, fIdxA, fGotA, dinA, dinVA, doutRA} !== 54'd0) begin
         miscompares++;
         $display("FAIL reset_A: got %h expected 0", {busyA, doneA, passA, toA, errA, fIdxA, fGotA, dinA, dinVA, doutRA});
      end
      vectors++;
      if ({busyB, doneB, passB, toB, errB, fIdxB, fGotB, dinB, dinVB, doutRB} !== 54'd0) begin
         miscompares++;
         $display("FAIL reset_B: got %h expected 0", {busyB, doneB, passB, toB, errB, fIdxB, fGotB, dinB, dinVB, doutRB});
      end
      rstN = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (doutRA !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 1", doutRA);
      end
   endtask

   // Common pass checks after a clean loopback run on instance s.
   task automatic test_loopback(input int s, input string tag);
      drive_run(s, -1, 8'd0, -1, 0, 0, 1'b0, 0);
      vectors++;
      if (runDone !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b expected 1 (budget)", tag, runDone); end
      vectors++;
      if ({firstBusy, firstValid, firstData} !== {1'b1, 1'b1, model_byte(s, 0)}) begin
         miscompares++;
         $display("FAIL %s_start: got busy/valid/data %b/%b/%h expected 1/1/%h", tag, firstBusy, firstValid, firstData, model_byte(s, 0));
      end
      vectors++;
      if (txLog.size() !== num_bytes(s)) begin miscompares++; $display("FAIL %s_txcount: got %0d expected %0d", tag, txLog.size(), num_bytes(s)); end
      for (int k = 0; k < txLog.size(); k++) begin
         vectors++;
         if (txLog[k] !== model_byte(s, k)) begin miscompares++; $display("FAIL %s_tx%0d: got %h expected %h", tag, k, txLog[k], model_byte(s, k)); end
      end
      vectors++;
      if (doneCycle !== lastEchoEdge) begin miscompares++; $display("FAIL %s_done_time: got %0d expected %0d", tag, doneCycle, lastEchoEdge); end
      vectors++;
      if ({passS, toS, busyS, errS} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL %s_result: got pass/to/busy/err %b/%b/%b/%0d expected 1/0/0/0", tag, passS, toS, busyS, errS);
      end
      vectors++;
      if (maxOut > window_of(s)) begin miscompares++; $display("FAIL %s_window: got %0d expected <= %0d", tag, maxOut, window_of(s)); end
   endtask

   task automatic test_lfsr_constants();
      logic [7:0] exp5 [5];
      exp5 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      test_loopback(1, "lfsr");
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (model_byte(1, k) !== exp5[k] || (k < txLog.size() && txLog[k] !== exp5[k])) begin
            miscompares++;
            $display("FAIL lfsr_const%0d: got %h expected %h", k, (k < txLog.size()) ? txLog[k] : 8'hxx, exp5[k]);
         end
      end
   endtask

   task automatic test_done_discard();
      repeat (3) begin
         dataOutValid = 1'b1; dataOut = 8'($urandom);
         @(posedge clk); #1;
      end
      dataOutValid = 1'b0;
      vectors++;
      if ({doneS, passS, busyS, errS} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL done_discard: got done/pass/busy/err %b/%b/%b/%0d expected 1/1/0/0", doneS, passS, busyS, errS);
      end
   endtask

   task automatic test_corrupt(input int idx, input logic [7:0] val, input string tag);
      int expErr;
      expErr = (val != model_byte(0, idx)) ? 1 : 0;
      drive_run(0, idx, val, -1, 0, 0, 1'b0, 0);
      vectors++;
      if (runDone !== 1'b1) begin miscompares++; $display("FAIL %s_done: got %b expected 1 (budget)", tag, runDone); end
      vectors++;
      if (errS !== 16'(expErr)) begin miscompares++; $display("FAIL %s_err: got %0d expected %0d", tag, errS, expErr); end
      vectors++;
      if ({fIdxS, fGotS} !== (expErr ? {16'(idx), val} : 24'd0)) begin
         miscompares++;
         $display("FAIL %s_first: got idx/got %0d/%h expected %0d/%h", tag, fIdxS, fGotS, expErr ? idx : 0, expErr ? val : 8'd0);
      end
      vectors++;
      if ({doneS, passS, toS} !== {1'b1, (expErr == 0), 1'b0}) begin
         miscompares++;
         $display("FAIL %s_pass: got done/pass/to %b/%b/%b expected 1/%0d/0", tag, doneS, passS, toS, expErr == 0);
      end
   endtask

   task automatic test_timeout();
      drive_run(0, -1, 8'd0, 3, 0, 0, 1'b0, 0);
      vectors++;
      if (runDone !== 1'b1) begin miscompares++; $display("FAIL timeout_done: got %b expected 1 (budget)", runDone); end
      vectors++;
      if (doneCycle !== lastClear + ToCycles) begin
         miscompares++;
         $display("FAIL timeout_time: got %0d expected %0d", doneCycle, lastClear + ToCycles);
      end
      vectors++;
      if ({doneS, toS, passS, errS} !== {1'b1, 1'b1, 1'b0, 16'd0}) begin
         miscompares++;
         $display("FAIL timeout_flags: got done/to/pass/err %b/%b/%b/%0d expected 1/1/0/0", doneS, toS, passS, errS);
      end
   endtask

   task automatic test_backpressure();
      drive_run(0, -1, 8'd0, -1, 10, 50, 1'b0, 0);
      vectors++;
      if (runDone !== 1'b1) begin miscompares++; $display("FAIL bp_done: got %b expected 1 (budget)", runDone); end
      vectors++;
      if (maxOut !== 2) begin miscompares++; $display("FAIL bp_window: got %0d expected 2", maxOut); end
      vectors++;
      if (stabViol !== 0 || stabChecks < 9) begin
         miscompares++;
         $display("FAIL bp_stable: got %0d changes in %0d held cycles expected 0 in >=9", stabViol, stabChecks);
      end
      vectors++;
      if ({passS, errS} !== {1'b1, 16'd0}) begin miscompares++; $display("FAIL bp_pass: got pass/err %b/%0d expected 1/0", passS, errS); end
      for (int k = 0; k < txLog.size(); k++) begin
         vectors++;
         if (txLog[k] !== model_byte(0, k)) begin miscompares++; $display("FAIL bp_tx%0d: got %h expected %h", k, txLog[k], model_byte(0, k)); end
      end
   endtask

   task automatic test_unexpected();
      drive_run(0, -1, 8'd0, -1, 0, 0, 1'b1, 0);
      vectors++;
      if (runDone !== 1'b1) begin miscompares++; $display("FAIL unexp_done: got %b expected 1 (budget)", runDone); end
      vectors++;
      if ({errS, fIdxS, fGotS, passS} !== {16'd1, 16'd0, 8'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL unexp_result: got err/idx/got/pass %0d/%0d/%h/%b expected 1/0/00/0", errS, fIdxS, fGotS, passS);
      end
   endtask

   task automatic test_reset_midrun();
      drive_run(0, -1, 8'd0, -1, 0, 0, 1'b0, 6);
      rstN = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({busyA, doneA, passA, toA, errA, fIdxA, fGotA, dinA, dinVA, doutRA} !== 54'd0) begin
         miscompares++;
         $display("FAIL midrst_vals: got %h expected 0", {busyA, doneA, passA, toA, errA, fIdxA, fGotA, dinA, dinVA, doutRA});
      end
      rstN = 1'b1;
      @(posedge clk); #1;
      dataOutValid = 1'b1; dataOut = 8'($urandom);
      @(posedge clk); #1;
      dataOutValid = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({busyA, doneA, errA, doutRA} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL midrst_idle: got busy/done/err/rdy %b/%b/%0d/%b expected 0/0/0/1", busyA, doneA, errA, doutRA);
      end
      test_loopback(0, "after_rst");
   endtask

   initial begin
      logic [7:0] rv;
      test_reset();
      test_loopback(0, "loop");
      test_done_discard();
      test_corrupt(2, 8'h00, "corrupt");
      rv = 8'($urandom);
      test_corrupt($urandom_range(0, 3), rv, "rcorrupt");
      test_lfsr_constants();
      test_timeout();
      test_backpressure();
      test_unexpected();
      test_reset_midrun();
      repeat (3) test_loopback(0, "rloop");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
